// File: rtl/mem_access_initiator.sv
// Load/store initiator for a byte-addressed, big-endian data memory port.
// Aligned accesses take one memory cycle; misaligned ones are split into byte cycles.
module mem_access_initiator #(
  parameter int MEM_BYTES   = 256,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_DI,
  input  logic [31:0] mem_DO,
  output logic [1:0]  mem_Size,
  output logic        mem_RW,
  output logic        mem_E
);

  typedef enum logic [1:0] {IDLE = 2'b00, XFER = 2'b01, SPLIT = 2'b10, RESP = 2'b11} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size, input logic sgn);
    case (size)
      2'b00:   extend = {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   extend = {{16{sgn & raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Byte k of an n-byte store, counted from the most significant end.
  function automatic logic [7:0] split_byte(input logic [31:0] wdata, input logic [1:0] size, input logic [1:0] k);
    logic [1:0] idx;
    idx = 2'(nbytes(size) - 3'd1 - {1'b0, k});
    split_byte = 8'(wdata >> {idx, 3'b000});
  endfunction

  state_t      state_q, state_d;
  logic        rw_q, rw_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]  size_q, size_d, k_q, k_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] raw_s;

  logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_a_q, mem_a_d, mem_di_q, mem_di_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_rw_q, mem_rw_d, mem_e_q, mem_e_d;

  logic [2:0]  req_n_s, cur_n_s;
  logic [32:0] req_end_s;
  logic        req_misal_s;

  assign req_n_s     = nbytes(req_size);
  assign cur_n_s     = nbytes(size_q);
  assign req_end_s   = {1'b0, req_addr} + {30'd0, req_n_s};
  assign req_misal_s = ((req_size == 2'b01) && req_addr[0]) || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;
    raw_s   = 32'd0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          rw_d    = req_rw;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = 2'd0;
          acc_d   = 24'd0;
          if ((req_size == 2'b11) || (req_end_s > MEM_LIMIT)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (!req_misal_s) begin
            state_d = XFER;
            err_d   = 1'b0;
          end else if (ALLOW_SPLIT) begin
            state_d = SPLIT;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        raw_s   = mem_DO;
        state_d = RESP;
      end
      SPLIT: begin
        acc_d = {acc_q[15:0], mem_DO[7:0]};
        raw_s = {acc_q, mem_DO[7:0]};
        if ({1'b0, k_q} == (cur_n_s - 3'd1)) begin
          state_d = RESP;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = SPLIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state and captured request.
  always_comb begin
    mem_a_d    = 32'd0;
    mem_di_d   = 32'd0;
    mem_size_d = 2'b00;
    mem_rw_d   = 1'b0;
    mem_e_d    = 1'b0;
    case (state_d)
      XFER: begin
        mem_a_d    = addr_d;
        mem_di_d   = wdata_d;
        mem_size_d = size_d;
        mem_rw_d   = rw_d;
        mem_e_d    = rw_d;
      end
      SPLIT: begin
        mem_a_d    = addr_d + {30'd0, k_d};
        mem_di_d   = {24'd0, split_byte(wdata_d, size_d, k_d)};
        mem_size_d = 2'b00;
        mem_rw_d   = rw_d;
        mem_e_d    = rw_d;
      end
      default: begin
        mem_a_d = 32'd0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && err_d;
    if ((state_d == RESP) && !err_d && !rw_d) begin
      rsp_rdata_d = extend(raw_s, size_d, sgn_d);
    end else begin
      rsp_rdata_d = 32'd0;
    end
  end

  // All state, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      k_q         <= 2'd0;
      acc_q       <= 24'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_di_q    <= 32'd0;
      mem_size_q  <= 2'b00;
      mem_rw_q    <= 1'b0;
      mem_e_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_a_q     <= mem_a_d;
      mem_di_q    <= mem_di_d;
      mem_size_q  <= mem_size_d;
      mem_rw_q    <= mem_rw_d;
      mem_e_q     <= mem_e_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_A     = mem_a_q;
  assign mem_DI    = mem_di_q;
  assign mem_Size  = mem_size_q;
  assign mem_RW    = mem_rw_q;
  assign mem_E     = mem_e_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Randomized and directed bench for mem_access_initiator against a byte-array
// reference model of the big-endian memory and the request rules.
module tb_mem_access_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, mem_load = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_rw = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_A, mem_DI, mem_DO;
  logic [1:0]  mem_Size;
  logic        mem_RW, mem_E;

  logic        ns_req_valid = 1'b0, ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_mem_RW, ns_mem_E;
  logic [1:0]  ns_req_size = 2'b00, ns_mem_Size;
  logic [31:0] ns_req_addr = 32'd0, ns_rsp_rdata, ns_mem_A, ns_mem_DI;

  logic [7:0] dmem [0:255];
  logic [7:0] ref_mem [0:255];
  int tests = 0, fails = 0;

  mem_access_initiator #(.MEM_BYTES(256), .ALLOW_SPLIT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_A(mem_A),
    .mem_DI(mem_DI), .mem_DO(mem_DO), .mem_Size(mem_Size), .mem_RW(mem_RW), .mem_E(mem_E));

  mem_access_initiator #(.MEM_BYTES(256), .ALLOW_SPLIT(1'b0)) u_dut_ns (
    .clk(clk), .reset(reset), .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_rw(1'b0),
    .req_size(ns_req_size), .req_signed(1'b1), .req_addr(ns_req_addr), .req_wdata(32'd0),
    .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err), .mem_A(ns_mem_A),
    .mem_DI(ns_mem_DI), .mem_DO(32'd0), .mem_Size(ns_mem_Size), .mem_RW(ns_mem_RW), .mem_E(ns_mem_E));

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16: return 8'h80;
      17: return 8'h01;
      18: return 8'hFE;
      19: return 8'h7F;
      default: return (i >= 128) ? (8'(i) ^ 8'h5A) : 8'h00;
    endcase
  endfunction

  // Big-endian memory model: combinational read, write on clock edge.
  always_comb begin
    case (mem_Size)
      2'b00:   mem_DO = {24'd0, dmem[mem_A[7:0]]};
      2'b01:   mem_DO = {16'd0, dmem[mem_A[7:0]], dmem[mem_A[7:0] + 8'd1]};
      default: mem_DO = {dmem[mem_A[7:0]], dmem[mem_A[7:0] + 8'd1], dmem[mem_A[7:0] + 8'd2], dmem[mem_A[7:0] + 8'd3]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_byte(i);
    end else if (mem_E) begin
      case (mem_Size)
        2'b00: dmem[mem_A[7:0]] <= mem_DI[7:0];
        2'b01: begin
          dmem[mem_A[7:0]]        <= mem_DI[15:8];
          dmem[mem_A[7:0] + 8'd1] <= mem_DI[7:0];
        end
        default: begin
          dmem[mem_A[7:0]]        <= mem_DI[31:24];
          dmem[mem_A[7:0] + 8'd1] <= mem_DI[23:16];
          dmem[mem_A[7:0] + 8'd2] <= mem_DI[15:8];
          dmem[mem_A[7:0] + 8'd3] <= mem_DI[7:0];
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: error rule, latency, write count and load value; applies stores to ref_mem.
  task automatic model(input logic rw, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int ecnt);
    int n;
    longint last, v;
    bit aligned;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    last = longint'(addr) + n;
    aligned = (addr % n) == 0;
    err = (size == 2'd3) || (last > 256);
    rdata = 32'd0;
    ecnt = 0;
    if (err) begin
      lat = 1;
    end else begin
      lat = aligned ? 2 : n + 1;
      if (rw) begin
        ecnt = aligned ? 1 : n;
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * (n - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(addr) + i]);
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rdata = 32'(v);
      end
    end
  endtask

  task automatic do_req(input string name, input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
    logic e_err, g_err, addr_ok;
    logic [31:0] e_rdata;
    logic [1:0] size1, e_size1;
    int e_lat, e_ecnt, lat, ecnt, w;
    model(rw, size, sgn, addr, wdata, e_err, e_rdata, e_lat, e_ecnt);
    got = 32'd0;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    tests++;
    if (!req_ready) begin fails++; $display("FAIL %s ready_wait: req_ready=%b want 1", name, req_ready); return; end
    req_rw = rw; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    size1 = mem_Size;
    lat = 0; ecnt = 0; addr_ok = 1'b1; g_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (rsp_valid) begin lat = c; got = rsp_rdata; g_err = rsp_err; break; end
      if (mem_E) begin
        if (mem_A !== addr + 32'(ecnt)) addr_ok = 1'b0;
        ecnt++;
      end
      tick();
    end
    tests++;
    if (lat != e_lat) begin fails++; $display("FAIL %s latency: got %0d want %0d (addr=%h size=%0d rw=%b)", name, lat, e_lat, addr, size, rw); end
    if (lat == 0) return;
    tests++;
    if (g_err !== e_err) begin fails++; $display("FAIL %s err: got %b want %b (addr=%h size=%0d)", name, g_err, e_err, addr, size); end
    tests++;
    if (got !== e_rdata) begin fails++; $display("FAIL %s rdata: got %h want %h (addr=%h size=%0d sgn=%b)", name, got, e_rdata, addr, size, sgn); end
    tests++;
    if (ecnt != e_ecnt) begin fails++; $display("FAIL %s write_cycles: got %0d want %0d", name, ecnt, e_ecnt); end
    e_size1 = (!e_err && e_lat == 2) ? size : 2'b00;
    tests++;
    if (size1 !== e_size1) begin fails++; $display("FAIL %s mem_size: got %b want %b", name, size1, e_size1); end
    tests++;
    if (!addr_ok) begin fails++; $display("FAIL %s mem_addr_seq: got bad address want %h+k", name, addr); end
    tick();
    tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL %s after_resp: got valid/ready=%b%b want 01", name, rsp_valid, req_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_load = 1'b1;
    repeat (3) tick();
    tests++;
    if ({req_ready, rsp_valid, rsp_err, mem_RW, mem_E, mem_Size} !== 7'b1000000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 1000000", {req_ready, rsp_valid, rsp_err, mem_RW, mem_E, mem_Size});
    end
    tests++;
    if ({rsp_rdata, mem_A, mem_DI} !== 96'd0) begin
      fails++; $display("FAIL reset_data: got rdata=%h A=%h DI=%h want 0", rsp_rdata, mem_A, mem_DI);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    reset = 1'b0; mem_load = 1'b0;
    tick();
  endtask

  task automatic test_loads();
    logic [31:0] got;
    do_req("word_load", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, got);
    tests++; if (got !== 32'h8001FE7F) begin fails++; $display("FAIL word_load_const: got %h want 8001FE7F", got); end
    do_req("sbyte_load", 1'b0, 2'b00, 1'b1, 32'h10, 32'd0, got);
    tests++; if (got !== 32'hFFFFFF80) begin fails++; $display("FAIL sbyte_const: got %h want FFFFFF80", got); end
    do_req("ubyte_load", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, got);
    tests++; if (got !== 32'h00000080) begin fails++; $display("FAIL ubyte_const: got %h want 00000080", got); end
    do_req("shalf_load", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, got);
    tests++; if (got !== 32'hFFFFFE7F) begin fails++; $display("FAIL shalf_const: got %h want FFFFFE7F", got); end
    do_req("split_hload", 1'b0, 2'b01, 1'b1, 32'h11, 32'd0, got);
    tests++; if (got !== 32'h000001FE) begin fails++; $display("FAIL split_hload_const: got %h want 000001FE", got); end
  endtask

  task automatic test_split_store();
    logic [31:0] got;
    do_req("split_store", 1'b1, 2'b10, 1'b0, 32'h21, 32'hDEADBEEF, got);
    do_req("load_after_split", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, got);
    tests++; if (got !== 32'h00DEADBE) begin fails++; $display("FAIL split_store_readback: got %h want 00DEADBE", got); end
    do_req("split_hstore", 1'b1, 2'b01, 1'b0, 32'h33, 32'hFFFF1234, got);
    do_req("load_after_hsplit", 1'b0, 2'b10, 1'b0, 32'h32, 32'd0, got);
    tests++; if (got !== 32'h00123400) begin fails++; $display("FAIL hsplit_readback: got %h want 00123400", got); end
  endtask

  task automatic test_errors();
    logic [31:0] got;
    do_req("size11", 1'b0, 2'b11, 1'b1, 32'h30, 32'd0, got);
    do_req("size11_store", 1'b1, 2'b11, 1'b0, 32'h30, 32'h12345678, got);
    do_req("word_oob", 1'b0, 2'b10, 1'b0, 32'hFD, 32'd0, got);
    do_req("word_edge", 1'b0, 2'b10, 1'b0, 32'hFC, 32'd0, got);
    do_req("byte_last", 1'b1, 2'b00, 1'b0, 32'hFF, 32'h000000A5, got);
    do_req("byte_oob", 1'b0, 2'b00, 1'b0, 32'h100, 32'd0, got);
    do_req("no_wrap", 1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h11, got);
  endtask

  task automatic test_no_split();
    ns_req_size = 2'b01; ns_req_addr = 32'h31; ns_req_valid = 1'b1;
    tick();
    ns_req_valid = 1'b0;
    tests++;
    if ({ns_rsp_valid, ns_rsp_err, ns_mem_E, ns_mem_Size} !== 5'b11000) begin
      fails++; $display("FAIL nosplit_err: got valid/err/E/size=%b want 11000", {ns_rsp_valid, ns_rsp_err, ns_mem_E, ns_mem_Size});
    end
    tick();
    ns_req_addr = 32'h30; ns_req_valid = 1'b1;
    tick();
    ns_req_valid = 1'b0;
    tests++;
    if ({ns_rsp_valid, ns_mem_Size, ns_req_ready} !== 4'b0010) begin
      fails++; $display("FAIL nosplit_xfer: got valid/size/ready=%b want 0010", {ns_rsp_valid, ns_mem_Size, ns_req_ready});
    end
    tick();
    tests++;
    if ({ns_rsp_valid, ns_rsp_err} !== 2'b10) begin
      fails++; $display("FAIL nosplit_aligned_rsp: got valid/err=%b want 10", {ns_rsp_valid, ns_rsp_err});
    end
    tick();
  endtask

  task automatic test_reset_mid_split();
    logic bad;
    req_rw = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h41; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tests++;
    if ({mem_E, mem_A} !== {1'b1, 32'h41}) begin fails++; $display("FAIL mid_first_byte: got E=%b A=%h want 1 41", mem_E, mem_A); end
    tick();
    reset = 1'b1;
    tick();
    tests++;
    if ({mem_E, rsp_valid, req_ready} !== 3'b001) begin
      fails++; $display("FAIL mid_reset_state: got E/valid/ready=%b want 001", {mem_E, rsp_valid, req_ready});
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid || mem_E) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad) begin fails++; $display("FAIL mid_no_resp: got rsp_valid or mem_E after reset want none"); end
    ref_mem[8'h41] = 8'hDE;
    ref_mem[8'h42] = 8'hAD;
    tests++;
    if ({dmem[8'h40], dmem[8'h41], dmem[8'h42], dmem[8'h43], dmem[8'h44]} !==
        {ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43], ref_mem[8'h44]}) begin
      fails++; $display("FAIL mid_partial_bytes: got %h%h%h%h%h want %h%h%h%h%h", dmem[8'h40], dmem[8'h41], dmem[8'h42],
        dmem[8'h43], dmem[8'h44], ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43], ref_mem[8'h44]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h10, 32'h14, 32'h12};
    logic [1:0]  sizes [3] = '{2'b10, 2'b10, 2'b01};
    logic [31:0] exp_d [3];
    logic e_err, acc;
    int lat, ecnt, sent, got, bad_ready;
    int pulses [$];
    for (int i = 0; i < 3; i++) model(1'b0, sizes[i], 1'b1, addrs[i], 32'd0, e_err, exp_d[i], lat, ecnt);
    sent = 0; got = 0; bad_ready = 0;
    req_rw = 1'b0; req_signed = 1'b1; req_wdata = 32'd0; req_addr = addrs[0]; req_size = sizes[0]; req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = req_valid && req_ready;
      if ((mem_Size != 2'b00 || rsp_valid) && req_ready) bad_ready++;
      if (rsp_valid) begin
        tests++;
        if (got >= 3 || rsp_rdata !== exp_d[got]) begin
          fails++; $display("FAIL b2b_rdata%0d: got %h want %h", got, rsp_rdata, (got < 3) ? exp_d[got] : 32'd0);
        end
        pulses.push_back(c);
        got++;
      end
      tick();
      if (acc) begin
        sent++;
        if (sent < 3) begin req_addr = addrs[sent]; req_size = sizes[sent]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    tests++;
    if (got != 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", got); end
    tests++;
    if (bad_ready != 0) begin fails++; $display("FAIL b2b_ready_low: got %0d busy cycles with ready want 0", bad_ready); end
    if (pulses.size() == 3) begin
      tests++;
      if (pulses[1] - pulses[0] != 3 || pulses[2] - pulses[1] != 3) begin
        fails++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", pulses[1] - pulses[0], pulses[2] - pulses[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] got, addr;
    logic rw, sgn;
    logic [1:0] size;
    int diffs;
    for (int i = 0; i < 200; i++) begin
      rw = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 263));
      if ($urandom_range(0, 9) == 0) addr[31:24] = 8'($urandom_range(1, 255));
      do_req("rand", rw, size, sgn, addr, $urandom, got);
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) diffs++;
    tests++;
    if (diffs != 0) begin fails++; $display("FAIL mem_contents: got %0d differing bytes want 0", diffs); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_split_store();
    test_errors();
    test_no_split();
    test_reset_mid_split();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
